// File: rtl/rv32m_muldiv_if.sv
// Execute-stage request/write-back bundle between the pipeline and the RV32M mul/div unit.
interface rv32m_muldiv_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  start;
    logic [2:0]            funct3;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  busy;
    logic                  done;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [XLEN-1:0]       write_data;
    logic                  write_enable;

    modport master (
        output start, funct3, rs1_data, rs2_data, rd_addr,
        input  busy, done, write_reg, write_data, write_enable
    );

    modport slave (
        input  start, funct3, rs1_data, rs2_data, rd_addr,
        output busy, done, write_reg, write_data, write_enable
    );
endinterface

// File: rtl/rv32m_muldiv.sv
// Iterative radix-2 RV32M multiply/divide unit: 32-step shift-add multiply,
// 32-step restoring divide, single-cycle handling of divide special cases.
module rv32m_muldiv #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    rv32m_muldiv_if.slave    bus
);
    localparam int unsigned DW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  neg_q, neg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]         acc_q, acc_d;
    logic [DW-1:0]         mcand_q, mcand_d;
    logic [XLEN-1:0]       mplier_q, mplier_d;
    logic [XLEN-1:0]       rem_q, rem_d;
    logic [XLEN-1:0]       quo_q, quo_d;
    logic [XLEN-1:0]       dvsr_q, dvsr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  we_q, we_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;

    // Operand decode and per-step datapath helpers
    logic            a_signed_c, b_signed_c, a_neg_c, b_neg_c;
    logic [XLEN-1:0] a_mag_c, b_mag_c;
    logic            div_zero_c, div_ovf_c;
    logic [DW-1:0]   acc_sum_c, product_c;
    logic [XLEN:0]   rem_shift_c;
    logic            rem_ge_c;
    logic [XLEN-1:0] rem_new_c, quo_new_c, div_res_c;
    logic            last_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        we_d     = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;

        // Signedness: MULH both, MULHSU rs1 only, DIV/REM both
        if (bus.funct3[2]) begin
            a_signed_c = ~bus.funct3[0];
            b_signed_c = ~bus.funct3[0];
        end else begin
            a_signed_c = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010);
            b_signed_c = (bus.funct3 == 3'b001);
        end
        a_neg_c    = a_signed_c & bus.rs1_data[XLEN-1];
        b_neg_c    = b_signed_c & bus.rs2_data[XLEN-1];
        a_mag_c    = a_neg_c ? XLEN'(XLEN'(0) - bus.rs1_data) : bus.rs1_data;
        b_mag_c    = b_neg_c ? XLEN'(XLEN'(0) - bus.rs2_data) : bus.rs2_data;
        div_zero_c = (bus.rs2_data == '0);
        div_ovf_c  = ~bus.funct3[0]
                   && (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.rs2_data == '1);

        last_c      = (cnt_q == CNT_W'(XLEN - 1));
        acc_sum_c   = acc_q + (mplier_q[0] ? mcand_q : '0);
        product_c   = neg_q ? DW'(DW'(0) - acc_sum_c) : acc_sum_c;
        rem_shift_c = {rem_q, quo_q[XLEN-1]};
        rem_ge_c    = (rem_shift_c >= {1'b0, dvsr_q});
        rem_new_c   = rem_ge_c ? XLEN'(rem_shift_c - {1'b0, dvsr_q}) : XLEN'(rem_shift_c);
        quo_new_c   = {quo_q[XLEN-2:0], rem_ge_c};
        div_res_c   = op_q[1] ? rem_new_c : quo_new_c;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d   = bus.funct3;
                    rd_d   = bus.rd_addr;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (!bus.funct3[2]) begin
                        state_d  = S_MUL;
                        neg_d    = a_neg_c ^ b_neg_c;
                        acc_d    = '0;
                        mcand_d  = DW'(a_mag_c);
                        mplier_d = b_mag_c;
                    end else if (div_zero_c || div_ovf_c) begin
                        // Result is known at accept; skip the iterations
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        we_d    = (bus.rd_addr != '0);
                        wreg_d  = bus.rd_addr;
                        if (div_zero_c)
                            wdata_d = bus.funct3[1] ? bus.rs1_data : '1;
                        else
                            wdata_d = bus.funct3[1] ? '0 : bus.rs1_data;
                    end else begin
                        state_d = S_DIV;
                        neg_d   = bus.funct3[1] ? a_neg_c : (a_neg_c ^ b_neg_c);
                        rem_d   = '0;
                        quo_d   = a_mag_c;
                        dvsr_d  = b_mag_c;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_sum_c;
                mcand_d  = {mcand_q[DW-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[XLEN-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_c) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    we_d    = (rd_q != '0);
                    wreg_d  = rd_q;
                    wdata_d = (op_q == 3'b000) ? product_c[XLEN-1:0] : product_c[DW-1:XLEN];
                end
            end
            S_DIV: begin
                rem_d = rem_new_c;
                quo_d = quo_new_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_c) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    we_d    = (rd_q != '0);
                    wreg_d  = rd_q;
                    wdata_d = neg_q ? XLEN'(XLEN'(0) - div_res_c) : div_res_c;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.write_enable = we_q;
    assign bus.write_reg    = wreg_q;
    assign bus.write_data   = wdata_q;
endmodule

// File: tb/tb_rv32m_muldiv.sv
// Directed self-checking bench for rv32m_muldiv: latency, results, special cases, rd=0, reset.
module tb_rv32m_muldiv;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    rv32m_muldiv_if #(.XLEN(32), .REG_ADDR_W(5)) bif ();

    rv32m_muldiv #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, watch it to completion, then check the return to idle.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_cyc, input bit poke);
        int cyc;
        int busy_low;
        int early_we;
        bit seen;
        bif.start    = 1'b1;
        bif.funct3   = f3;
        bif.rs1_data = a;
        bif.rs2_data = b;
        bif.rd_addr  = rd;
        tick();
        bif.start    = 1'b0;
        bif.funct3   = 3'($urandom);
        bif.rs1_data = $urandom;
        bif.rs2_data = $urandom;
        bif.rd_addr  = 5'($urandom);
        cyc = 1; busy_low = 0; early_we = 0; seen = 1'b0;
        while (!seen && cyc <= 40) begin
            if (bif.done) begin
                seen = 1'b1;
            end else begin
                if (!bif.busy) busy_low++;
                if (bif.write_enable) early_we++;
                bif.start = poke && (cyc == 10);
                tick();
                cyc++;
            end
        end
        bif.start = 1'b0;
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " busy_before_done_low"}, 32'(busy_low), 32'd0);
        check({tag, " early_we"}, 32'(early_we), 32'd0);
        check({tag, " busy_in_done"}, 32'(bif.busy), 32'd1);
        check({tag, " write_data"}, bif.write_data, exp);
        check({tag, " write_reg"}, 32'(bif.write_reg), 32'(rd));
        check({tag, " write_enable"}, 32'(bif.write_enable), 32'(rd != 5'd0));
        tick();
        check({tag, " idle_done"}, 32'(bif.done), 32'd0);
        check({tag, " idle_we"}, 32'(bif.write_enable), 32'd0);
        check({tag, " idle_busy"}, 32'(bif.busy), 32'd0);
        check({tag, " idle_hold_data"}, bif.write_data, exp);
    endtask

    initial begin
        int wes;
        rst          = 1'b1;
        bif.start    = 1'b0;
        bif.funct3   = 3'd0;
        bif.rs1_data = 32'd0;
        bif.rs2_data = 32'd0;
        bif.rd_addr  = 5'd0;
        tick();
        tick();
        check("rst busy", 32'(bif.busy), 32'd0);
        check("rst done", 32'(bif.done), 32'd0);
        check("rst we", 32'(bif.write_enable), 32'd0);
        check("rst wreg", 32'(bif.write_reg), 32'd0);
        check("rst wdata", bif.write_data, 32'd0);
        rst = 1'b0;
        tick();

        // Multiply, incl. a start pulse mid-operation that must be ignored
        run_op("mul7x6",   3'b000, 32'd7,        32'd6,        5'd1,  32'd42,       33, 1'b1);
        run_op("mul_lo",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000001, 33, 1'b0);
        run_op("mulh",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, 33, 1'b0);
        run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 33, 1'b0);
        run_op("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 33, 1'b0);
        run_op("mulh_neg", 3'b001, 32'hFFFFFFFE, 32'h00000003, 5'd6,  32'hFFFFFFFF, 33, 1'b0);

        // Divide / remainder
        run_op("div_m7_2",   3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 33, 1'b1);
        run_op("rem_m7_2",   3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 33, 1'b0);
        run_op("divu_m7_2",  3'b101, 32'hFFFFFFF9, 32'd2,        5'd9,  32'h7FFFFFFC, 33, 1'b0);
        run_op("remu_m7_2",  3'b111, 32'hFFFFFFF9, 32'd2,        5'd10, 32'h00000001, 33, 1'b0);
        run_op("div_100_m7", 3'b100, 32'd100,      32'hFFFFFFF9, 5'd11, 32'hFFFFFFF2, 33, 1'b0);
        run_op("rem_100_m7", 3'b110, 32'd100,      32'hFFFFFFF9, 5'd12, 32'h00000002, 33, 1'b0);

        // Special cases complete the cycle after accept
        run_op("divu_by0", 3'b101, 32'h00001234, 32'd0,        5'd13, 32'hFFFFFFFF, 1, 1'b0);
        run_op("remu_by0", 3'b111, 32'h00001234, 32'd0,        5'd14, 32'h00001234, 1, 1'b0);
        run_op("div_by0",  3'b100, 32'hFFFFFFF9, 32'd0,        5'd15, 32'hFFFFFFFF, 1, 1'b0);
        run_op("rem_by0",  3'b110, 32'hFFFFFFF9, 32'd0,        5'd16, 32'hFFFFFFF9, 1, 1'b0);
        run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 1, 1'b0);
        run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h00000000, 1, 1'b0);

        // Destination x0: done pulses without a write strobe
        run_op("mul_rd0", 3'b000, 32'd3, 32'd3, 5'd0, 32'd9, 33, 1'b0);

        // Reset in the middle of a divide abandons it
        bif.start    = 1'b1;
        bif.funct3   = 3'b100;
        bif.rs1_data = 32'd1000;
        bif.rs2_data = 32'd7;
        bif.rd_addr  = 5'd20;
        tick();
        bif.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        check("rstmid busy", 32'(bif.busy), 32'd0);
        check("rstmid we", 32'(bif.write_enable), 32'd0);
        check("rstmid done", 32'(bif.done), 32'd0);
        rst = 1'b0;
        wes = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bif.write_enable || bif.done) wes++;
        end
        check("rstmid no_write", 32'(wes), 32'd0);
        run_op("mul5x5", 3'b000, 32'd5, 32'd5, 5'd21, 32'd25, 33, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
